// File: rtl/slreq_fifo.sv
// -----------------------------------------------------------------------------
// slreq_fifo
//   Single-bit FIFO feeding a downstream set-latch through a four-phase
//   req/ack handshake. Each queued bit is presented on d while req is high;
//   the downstream acknowledges, req drops, and the next bit is only offered
//   once ack has returned low.
//
// Parameters
//   DEPTH    queue depth in entries (power of two, 2..16)
//
// Ports
//   clk      in   sole clock, rising edge
//   res_n    in   asynchronous active-low reset
//   wr       in   write strobe, one bit enqueued per sampled-high cycle
//   wd       in   data bit enqueued with wr
//   req      out  four-phase request to downstream
//   d        out  data presented with req
//   ack      in   four-phase acknowledge from downstream
//   full     out  queue holds DEPTH entries
//   empty    out  queue holds zero entries
//   level    out  current entry count
//   ovf      out  sticky overflow flag
//   ovf_clr  in   synchronous clear of ovf
// -----------------------------------------------------------------------------
module slreq_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   wr,
    input  logic                   wd,
    output logic                   req,
    output logic                   d,
    input  logic                   ack,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]    LVL_ONE  = 1;
    localparam logic [AW-1:0]  PTR_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic             r_d;
    logic             w_d_nxt;
    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [AW:0]      w_level_nxt;
    logic             r_ovf;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_evt;

    // Status flags come only from the registered level.
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // A full queue still accepts a write when the head leaves on the same
    // edge; the write lands in the slot being vacated.
    assign w_push    = wr & (~w_full | w_pop);
    assign w_ovf_evt = wr & w_full & ~w_pop;

    // Handshake next-state; the head is popped on the edge that raises req.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_d_nxt     = r_d;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = REQ;
                    w_req_nxt   = 1'b1;
                    w_d_nxt     = r_mem[r_rptr];
                    w_pop       = 1'b1;
                end
            end
            REQ: begin
                if (ack) begin
                    w_state_nxt = REL;
                    w_req_nxt   = 1'b0;
                end
            end
            REL: begin
                // A stuck-high ack simply parks the FSM here.
                if (!ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_d     <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_d     <= w_d_nxt;
            r_level <= w_level_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            // Overflow set takes priority over a simultaneous clear.
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wd;
        end
    end

    assign req   = r_req;
    assign d     = r_d;
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_slreq_fifo.sv
// -----------------------------------------------------------------------------
// tb_slreq_fifo
//   Directed bench for slreq_fifo (DEPTH=4). A scoreboard queue receives each
//   bit the bench expects the FIFO to accept; every rising req pops the queue
//   and compares against d. Level/full/empty/ovf are tracked by a small model
//   and compared after every clock edge.
// -----------------------------------------------------------------------------
module tb_slreq_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       res_n;
    logic       wr;
    logic       wd;
    logic       req;
    logic       d;
    logic       ack;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       ovf;
    logic       ovf_clr;

    slreq_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .res_n   (res_n),
        .wr      (wr),
        .wd      (wd),
        .req     (req),
        .d       (d),
        .ack     (ack),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    bit   exp_q[$];
    int   mlevel;
    bit   movf;
    bit   auto_ack;
    logic req_hist;
    logic req_prev;
    logic d_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mlevel   = 0;
        movf     = 1'b0;
        req_prev = 1'b0;
        req_hist = 1'b0;
        d_prev   = 1'b0;
    endtask

    // One clock edge: update the model from the inputs that were applied,
    // score the DUT, then run the responder (ack follows req one cycle late).
    task automatic tick();
        logic s_wr;
        logic s_wd;
        logic s_clr;
        logic pop;
        int   lvl_b;
        s_wr  = wr;
        s_wd  = wd;
        s_clr = ovf_clr;
        lvl_b = mlevel;
        @(posedge clk);
        #1;
        pop = 1'b0;
        if (req && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("req_without_entry", req, 0);
            end else begin
                check("d_at_req", d, exp_q.pop_front());
                pop    = 1'b1;
                mlevel = mlevel - 1;
            end
        end else begin
            check("d_hold", d, d_prev);
        end
        if (s_wr) begin
            if (lvl_b < DEPTH || pop) begin
                exp_q.push_back(s_wd);
                mlevel = mlevel + 1;
            end else begin
                movf = 1'b1;
            end
        end
        if (!(s_wr && lvl_b == DEPTH && !pop) && s_clr) begin
            movf = 1'b0;
        end
        check("level", level, mlevel);
        check("full", full, (mlevel == DEPTH));
        check("empty", empty, (mlevel == 0));
        check("ovf", ovf, movf);
        req_prev = req;
        d_prev   = d;
        if (auto_ack) begin
            ack = req_hist;
        end
        req_hist = req;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || req || ack) && guard < 80) begin
            tick();
            guard++;
        end
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle_req"}, req, 0);
        tick();
        tick();
        check({tag, "_empty"}, empty, 1);
        check({tag, "_level"}, level, 0);
    endtask

    initial begin
        res_n    = 1'b0;
        wr       = 1'b0;
        wd       = 1'b0;
        ack      = 1'b0;
        ovf_clr  = 1'b0;
        auto_ack = 1'b0;
        model_reset();

        // Reset state, before any clock edge.
        #3;
        check("rst_req", req, 0);
        check("rst_d", d, 0);
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        res_n = 1'b1;

        // Single write, delayed responder: req high across edges 1..3.
        auto_ack = 1'b1;
        wr = 1'b1; wd = 1'b1;
        tick();
        wr = 1'b0;
        check("single_req_e0", req, 0);
        tick();
        check("single_req_e1", req, 1);
        tick();
        check("single_req_e2", req, 1);
        tick();
        check("single_req_e3", req, 0);
        drain("single");

        // Fill to full behind a held request, then overflow and clear.
        auto_ack = 1'b0;
        ack = 1'b0;
        wr = 1'b1; wd = 1'b0;
        tick();
        wd = 1'b1; tick();
        wd = 1'b0; tick();
        wd = 1'b1; tick();
        wd = 1'b1; tick();
        check("burst_full", full, 1);
        check("burst_level", level, 4);
        check("burst_req_held", req, 1);
        wd = 1'b0; tick();
        check("ovf_set", ovf, 1);
        check("ovf_level", level, 4);
        ovf_clr = 1'b1; tick();
        check("ovf_set_wins", ovf, 1);
        wr = 1'b0; tick();
        check("ovf_cleared", ovf, 0);
        ovf_clr = 1'b0;
        auto_ack = 1'b1;
        req_hist = req;
        drain("burst");

        // Ack stuck high parks the FSM in REL; queue keeps filling.
        auto_ack = 1'b0;
        ack = 1'b0;
        wr = 1'b1; wd = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        check("stuck_req_up", req, 1);
        ack = 1'b1;
        tick();
        check("stuck_req_down", req, 0);
        wr = 1'b1;
        wd = 1'b1; tick(); check("stuck_req0_a", req, 0);
        wd = 1'b0; tick(); check("stuck_req0_b", req, 0);
        wd = 1'b0; tick(); check("stuck_req0_c", req, 0);
        wd = 1'b1; tick(); check("stuck_req0_d", req, 0);
        wr = 1'b0;
        tick();
        check("stuck_full", full, 1);
        check("stuck_level", level, 4);
        check("stuck_req0_e", req, 0);

        // Full with FSM back in IDLE: write coincides with the pop.
        ack = 1'b0;
        tick();
        check("rel_to_idle_req", req, 0);
        wr = 1'b1; wd = 1'b0;
        tick();
        wr = 1'b0;
        check("fullpop_level", level, 4);
        check("fullpop_ovf", ovf, 0);
        check("fullpop_req", req, 1);
        auto_ack = 1'b1;
        req_hist = req;
        drain("fullpop");

        // Asynchronous reset in the middle of a request with 3 entries queued.
        auto_ack = 1'b0;
        ack = 1'b0;
        wr = 1'b1;
        wd = 1'b1; tick();
        wd = 1'b0; tick();
        wd = 1'b1; tick();
        wd = 1'b0; tick();
        wr = 1'b0;
        check("pre_rst_level", level, 3);
        check("pre_rst_req", req, 1);
        #2;
        res_n = 1'b0;
        #1;
        check("mid_rst_req", req, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_d", d, 0);
        model_reset();
        #1;
        res_n = 1'b1;
        wr = 1'b1; wd = 1'b1;
        tick();
        wr = 1'b0;
        check("post_rst_level", level, 1);
        auto_ack = 1'b1;
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
